servo_pwm_array: RTL and testbench

//  N-channel servo PWM generator with a shared frame timebase, command clamping, per-frame slew limiting and a
//  per-channel safety inhibit. Replaces the separate per-axis steering PWM blocks under the steering top. Joystick

---
 rtl/servo_pkg.sv | 41 ++++
 rtl/servo_pwm_ch.sv | 96 +++++++++
 rtl/servo_pwm_array.sv | 106 ++++++++++
 tb/tb_servo_pwm_array.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// -----------------------------------------------------------------------------
// servo_pkg
// Shared types and helpers for the servo PWM array.
//   PW_W      : width of every pulse-width quantity, in microseconds
//   pw_us_t   : unsigned pulse width in microseconds
//   pw_clamp  : limits a commanded width to [min_v, max_v]
//   pw_slew   : moves a width toward a target by at most one step
// -----------------------------------------------------------------------------
package servo_pkg;

    localparam int PW_W = 11;

    typedef logic [PW_W-1:0] pw_us_t;

    function automatic pw_us_t pw_clamp(pw_us_t v, pw_us_t min_v, pw_us_t max_v);
        if (v < min_v) begin
            return min_v;
        end else if (v > max_v) begin
            return max_v;
        end else begin
            return v;
        end
    endfunction

    // The difference is taken one bit wider and signed so a target below the
    // current width yields a negative value instead of wrapping.
    function automatic pw_us_t pw_slew(pw_us_t cur, pw_us_t tgt, pw_us_t step);
        logic signed [PW_W:0] diff;
        logic signed [PW_W:0] stp;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        stp  = $signed({1'b0, step});
        if (diff > stp) begin
            return cur + step;
        end else if (diff < -stp) begin
            return cur - step;
        end else begin
            return tgt;
        end
    endfunction

endpackage

// File: rtl/servo_pwm_ch.sv
// -----------------------------------------------------------------------------
// servo_pwm_ch
// One servo channel: command shadow with clamping, width applied at frame
// boundaries (inhibit / slew aware) and the registered PWM compare.
// Ports:
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   boundary_i   high for the single clk cycle that opens a frame
//   fcnt_i       frame position in microseconds
//   pw_cmd_i     commanded width (us), captured on cmd_we_i
//   cmd_we_i     write strobe for pw_cmd_i
//   inhibit_i    safety inhibit, level-sensitive
//   pwm_o        registered PWM output
//   pw_active_o  width currently applied (us)
//   sat_o        1-cycle pulse when the last write was clamped
// -----------------------------------------------------------------------------
module servo_pwm_ch
    import servo_pkg::*;
#(
    parameter int PW_MIN_US = 1000,
    parameter int PW_MAX_US = 2000,
    parameter int SLEW_US   = 0,
    parameter int FCNT_W    = 15
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              boundary_i,
    input  logic [FCNT_W-1:0] fcnt_i,
    input  pw_us_t            pw_cmd_i,
    input  logic              cmd_we_i,
    input  logic              inhibit_i,
    output logic              pwm_o,
    output pw_us_t            pw_active_o,
    output logic              sat_o
);

    localparam pw_us_t PW_LO   = pw_us_t'(PW_MIN_US);
    localparam pw_us_t PW_HI   = pw_us_t'(PW_MAX_US);
    localparam pw_us_t PW_CTR  = pw_us_t'((PW_MIN_US + PW_MAX_US) / 2);
    localparam pw_us_t PW_STEP = pw_us_t'(SLEW_US);

    pw_us_t shadow_q,  shadow_d;
    pw_us_t applied_q, applied_d;
    logic   inh_q;
    logic   sat_q,     sat_d;
    logic   pwm_q,     pwm_d;

    always_comb begin
        shadow_d = shadow_q;
        sat_d    = 1'b0;
        if (cmd_we_i) begin
            shadow_d = pw_clamp(pw_cmd_i, PW_LO, PW_HI);
            sat_d    = (pw_cmd_i < PW_LO) || (pw_cmd_i > PW_HI);
        end

        // The boundary looks at shadow_q and inh_q, i.e. the values settled
        // before the boundary cycle; a write in that very cycle lands in
        // shadow_d and waits for the next frame.
        applied_d = applied_q;
        if (boundary_i) begin
            if (inh_q) begin
                applied_d = PW_CTR;
            end else if (SLEW_US == 0) begin
                applied_d = shadow_q;
            end else begin
                applied_d = pw_slew(applied_q, shadow_q, PW_STEP);
            end
        end

        // Compare against the width valid for the cycle being registered, so
        // the first cycle of a frame already uses the new width and the pulse
        // is exactly applied * clk-per-us cycles long.
        pwm_d = (32'(fcnt_i) < 32'(applied_d));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow_q  <= PW_CTR;
            applied_q <= PW_CTR;
            inh_q     <= 1'b0;
            sat_q     <= 1'b0;
            pwm_q     <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            applied_q <= applied_d;
            inh_q     <= inhibit_i;
            sat_q     <= sat_d;
            pwm_q     <= pwm_d;
        end
    end

    assign pwm_o       = pwm_q;
    assign pw_active_o = applied_q;
    assign sat_o       = sat_q;

endmodule

// File: rtl/servo_pwm_array.sv
// -----------------------------------------------------------------------------
// servo_pwm_array
// N-channel servo PWM generator sharing one frame timebase. Commands are
// clamped into a shadow register, applied at frame boundaries with optional
// per-frame slew limiting, and forced to centre while inhibited.
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   pw_cmd       commanded width per channel (us), channel k at [11k+10:11k]
//   cmd_we       per-channel write strobe
//   inhibit      per-channel safety inhibit, level-sensitive
//   pwm_out      registered servo PWM outputs
//   pw_active    width currently applied per channel (us)
//   sat          per-channel 1-cycle pulse when a write was clamped
//   frame_start  1-cycle pulse on the first clk of each frame
// -----------------------------------------------------------------------------
module servo_pwm_array
    import servo_pkg::*;
#(
    parameter int N_CH      = 3,
    parameter int CLK_HZ    = 100_000_000,
    parameter int FRAME_US  = 20000,
    parameter int PW_MIN_US = 1000,
    parameter int PW_MAX_US = 2000,
    parameter int SLEW_US   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CH*PW_W-1:0] pw_cmd,
    input  logic [N_CH-1:0]      cmd_we,
    input  logic [N_CH-1:0]      inhibit,
    output logic [N_CH-1:0]      pwm_out,
    output logic [N_CH*PW_W-1:0] pw_active,
    output logic [N_CH-1:0]      sat,
    output logic                 frame_start
);

    localparam int DIV    = CLK_HZ / 1_000_000;
    localparam int PRE_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int FCNT_W = $clog2(FRAME_US);

    if (CLK_HZ % 1_000_000 != 0) begin : g_bad_clk
        $error("CLK_HZ must be an integer multiple of 1 MHz");
    end
    if (!(PW_MIN_US < PW_MAX_US && PW_MAX_US < FRAME_US)) begin : g_bad_range
        $error("pulse limits must satisfy PW_MIN_US < PW_MAX_US < FRAME_US");
    end
    if (PW_MAX_US >= 2048) begin : g_bad_width
        $error("PW_MAX_US must fit in 11 bits");
    end

    logic [PRE_W-1:0]  presc_q, presc_d;
    logic [FCNT_W-1:0] fcnt_q,  fcnt_d;
    logic              us_tick;
    logic              boundary;
    logic              frame_start_q;

    // Prescaler divides clk down to 1 us; fcnt counts microseconds in a frame.
    // With DIV == 1 the prescaler stays at 0 and ticks every cycle.
    always_comb begin
        us_tick = (presc_q == PRE_W'(DIV - 1));
        presc_d = us_tick ? '0 : presc_q + PRE_W'(1);
        fcnt_d  = fcnt_q;
        if (us_tick) begin
            fcnt_d = (fcnt_q == FCNT_W'(FRAME_US - 1)) ? '0 : fcnt_q + FCNT_W'(1);
        end
        // Both counters restart at 0 after reset, so the first cycle after
        // release is itself a boundary.
        boundary = (presc_q == '0) && (fcnt_q == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q       <= '0;
            fcnt_q        <= '0;
            frame_start_q <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            fcnt_q        <= fcnt_d;
            frame_start_q <= boundary;
        end
    end

    assign frame_start = frame_start_q;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        servo_pwm_ch #(
            .PW_MIN_US (PW_MIN_US),
            .PW_MAX_US (PW_MAX_US),
            .SLEW_US   (SLEW_US),
            .FCNT_W    (FCNT_W)
        ) u_ch (
            .clk_i       (clk),
            .rst_ni      (rst),
            .boundary_i  (boundary),
            .fcnt_i      (fcnt_q),
            .pw_cmd_i    (pw_cmd[k*PW_W +: PW_W]),
            .cmd_we_i    (cmd_we[k]),
            .inhibit_i   (inhibit[k]),
            .pwm_o       (pwm_out[k]),
            .pw_active_o (pw_active[k*PW_W +: PW_W]),
            .sat_o       (sat[k])
        );
    end

endmodule

// File: tb/tb_servo_pwm_array.sv
// -----------------------------------------------------------------------------
// tb_servo_pwm_array
// Two instances share inputs: dut_a without slew limit, dut_b with a 10 us
// per-frame slew limit. Scaled timebase: 2 clk per us, 300 us frames,
// widths 100..200 us (centre 150), so one frame is 600 clk.
// -----------------------------------------------------------------------------
module tb_servo_pwm_array;

    localparam int N_CH   = 3;
    localparam int CLK_HZ = 2_000_000;
    localparam int FRAME  = 300;
    localparam int PMIN   = 100;
    localparam int PMAX   = 200;
    localparam int SLEW_B = 10;
    localparam int DIV    = CLK_HZ / 1_000_000;
    localparam int P      = DIV * FRAME;
    localparam int CTR    = (PMIN + PMAX) / 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [N_CH*11-1:0]  pw_cmd;
    logic [N_CH-1:0]     cmd_we;
    logic [N_CH-1:0]     inhibit;
    logic [N_CH-1:0]     pwm_a, pwm_b, sat_a, sat_b;
    logic [N_CH*11-1:0]  act_a, act_b;
    logic                fs_a, fs_b;

    servo_pwm_array #(
        .N_CH(N_CH), .CLK_HZ(CLK_HZ), .FRAME_US(FRAME),
        .PW_MIN_US(PMIN), .PW_MAX_US(PMAX), .SLEW_US(0)
    ) dut_a (
        .clk(clk), .rst(rst), .pw_cmd(pw_cmd), .cmd_we(cmd_we), .inhibit(inhibit),
        .pwm_out(pwm_a), .pw_active(act_a), .sat(sat_a), .frame_start(fs_a)
    );

    servo_pwm_array #(
        .N_CH(N_CH), .CLK_HZ(CLK_HZ), .FRAME_US(FRAME),
        .PW_MIN_US(PMIN), .PW_MAX_US(PMAX), .SLEW_US(SLEW_B)
    ) dut_b (
        .clk(clk), .rst(rst), .pw_cmd(pw_cmd), .cmd_we(cmd_we), .inhibit(inhibit),
        .pwm_out(pwm_b), .pw_active(act_b), .sat(sat_b), .frame_start(fs_b)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: time is the number of rising edges since reset release.
    int          edge_cnt;      // index of the next rising edge
    int          last_edge;     // index of the edge just taken
    int          shadow_m [2][N_CH];
    int          applied_m[2][N_CH];
    int          inh_m    [N_CH];
    int          sat_m    [N_CH];
    int          slew_of  [2];
    logic [2:0]  inh_cur;

    task automatic chk(input string tag, input int d, input int k,
                       input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s dut%0d ch%0d edge=%0d observed=%0d expected=%0d",
                   tag, d, k, last_edge, obs, exp);
        end
    endtask

    function automatic logic [31:0] o_pwm(int d, int k);
        return (d == 0) ? 32'(pwm_a[k]) : 32'(pwm_b[k]);
    endfunction
    function automatic logic [31:0] o_act(int d, int k);
        return (d == 0) ? 32'(act_a[k*11 +: 11]) : 32'(act_b[k*11 +: 11]);
    endfunction
    function automatic logic [31:0] o_sat(int d, int k);
        return (d == 0) ? 32'(sat_a[k]) : 32'(sat_b[k]);
    endfunction
    function automatic logic [31:0] o_fs(int d);
        return (d == 0) ? 32'(fs_a) : 32'(fs_b);
    endfunction

    task automatic model_reset();
        edge_cnt  = 0;
        last_edge = -1;
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < N_CH; k++) begin
                shadow_m[d][k]  = CTR;
                applied_m[d][k] = CTR;
            end
        for (int k = 0; k < N_CH; k++) begin
            inh_m[k] = 0;
            sat_m[k] = 0;
        end
    endtask

    // What one rising edge does, from the behavioural rules.
    task automatic model_edge(input logic [2:0] we, input int c0, input int c1, input int c2,
                              input logic [2:0] inh);
        int cmd[N_CH];
        int cl;
        int diff;
        cmd[0] = c0; cmd[1] = c1; cmd[2] = c2;
        if (edge_cnt % P == 0) begin
            for (int d = 0; d < 2; d++)
                for (int k = 0; k < N_CH; k++) begin
                    if (inh_m[k] != 0) begin
                        applied_m[d][k] = CTR;
                    end else if (slew_of[d] == 0) begin
                        applied_m[d][k] = shadow_m[d][k];
                    end else begin
                        diff = shadow_m[d][k] - applied_m[d][k];
                        if (diff > slew_of[d])       applied_m[d][k] += slew_of[d];
                        else if (diff < -slew_of[d]) applied_m[d][k] -= slew_of[d];
                        else                         applied_m[d][k] = shadow_m[d][k];
                    end
                end
        end
        for (int k = 0; k < N_CH; k++) begin
            sat_m[k] = 0;
            if (we[k]) begin
                cl = (cmd[k] < PMIN) ? PMIN : (cmd[k] > PMAX) ? PMAX : cmd[k];
                sat_m[k] = (cl != cmd[k]) ? 1 : 0;
                for (int d = 0; d < 2; d++) shadow_m[d][k] = cl;
            end
            inh_m[k] = inh[k] ? 1 : 0;
        end
        last_edge = edge_cnt;
        edge_cnt++;
    endtask

    task automatic compare_all();
        for (int d = 0; d < 2; d++) begin
            chk("frame_start", d, 0, o_fs(d), 32'((last_edge % P) == 0));
            for (int k = 0; k < N_CH; k++) begin
                chk("pwm_out",   d, k, o_pwm(d, k), 32'(((last_edge % P) / DIV) < applied_m[d][k]));
                chk("pw_active", d, k, o_act(d, k), 32'(applied_m[d][k]));
                chk("sat",       d, k, o_sat(d, k), 32'(sat_m[k]));
            end
        end
    endtask

    task automatic chk_reset();
        for (int d = 0; d < 2; d++) begin
            chk("rst_frame_start", d, 0, o_fs(d), 32'd0);
            for (int k = 0; k < N_CH; k++) begin
                chk("rst_pwm_out",   d, k, o_pwm(d, k), 32'd0);
                chk("rst_sat",       d, k, o_sat(d, k), 32'd0);
                chk("rst_pw_active", d, k, o_act(d, k), 32'(CTR));
            end
        end
    endtask

    // Drive one cycle of inputs (called after a falling edge), take the rising
    // edge, then compare on the following falling edge.
    task automatic step(input logic [2:0] we, input int c0, input int c1, input int c2);
        cmd_we  = we;
        pw_cmd  = {11'(c2), 11'(c1), 11'(c0)};
        inhibit = inh_cur;
        @(posedge clk);
        model_edge(we, c0, c1, c2, inh_cur);
        @(negedge clk);
        compare_all();
        cmd_we = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(3'b000, 0, 0, 0);
    endtask

    // Steps until the edge just taken opened a frame.
    task automatic run_to_boundary();
        do idle(1); while (last_edge % P != 0);
    endtask

    // Steps until the next edge will open a frame.
    task automatic run_to_pre_boundary();
        while (edge_cnt % P != 0) idle(1);
    endtask

    initial begin
        int hi;
        slew_of[0] = 0;
        slew_of[1] = SLEW_B;
        inh_cur    = '0;
        rst        = 1'b0;
        cmd_we     = '0;
        pw_cmd     = '0;
        inhibit    = '0;
        model_reset();

        // Reset held for 10 cycles, then the first frame at centre width.
        repeat (10) begin
            @(negedge clk);
            chk_reset();
        end
        rst = 1'b1;
        hi  = 0;
        for (int i = 0; i < P; i++) begin
            idle(1);
            hi += int'(pwm_a[0]);
        end
        chk("first_pulse_len", 0, 0, 32'(hi), 32'(CTR * DIV));

        // Mid-frame write to ch0: current frame unchanged, next frame applies.
        idle(FRAME);
        step(3'b001, 180, 0, 0);
        chk("midframe_hold", 0, 0, o_act(0, 0), 32'(CTR));
        run_to_boundary();
        chk("midframe_apply", 0, 0, o_act(0, 0), 32'd180);
        chk("midframe_slew",  1, 0, o_act(1, 0), 32'(CTR + SLEW_B));
        chk("midframe_ch1",   0, 1, o_act(0, 1), 32'(CTR));
        run_to_boundary();

        // Clamping on ch1: high, low, in range.
        idle(20);
        step(3'b010, 0, 2047, 0);
        chk("sat_high", 0, 1, o_sat(0, 1), 32'd1);
        step(3'b010, 0, 50, 0);
        chk("sat_low", 0, 1, o_sat(0, 1), 32'd1);
        step(3'b010, 0, 120, 0);
        chk("sat_none", 0, 1, o_sat(0, 1), 32'd0);
        run_to_boundary();
        chk("clamp_apply", 0, 1, o_act(0, 1), 32'd120);

        // Slew on ch2: 150 -> 200 in steps of 10 on dut_b, immediate on dut_a.
        idle(100);
        step(3'b100, 0, 0, 200);
        for (int i = 1; i <= 7; i++) begin
            run_to_boundary();
            chk("slew_ch2",   1, 2, o_act(1, 2), 32'((CTR + SLEW_B * i > PMAX) ? PMAX : CTR + SLEW_B * i));
            chk("noslew_ch2", 0, 2, o_act(0, 2), 32'd200);
        end

        // Inhibit on ch0 forces centre, then slew resumes from centre.
        idle(50);
        step(3'b001, 190, 0, 0);
        repeat (3) run_to_boundary();
        idle(200);
        inh_cur = 3'b001;
        run_to_boundary();
        chk("inhibit_a", 0, 0, o_act(0, 0), 32'(CTR));
        chk("inhibit_b", 1, 0, o_act(1, 0), 32'(CTR));
        inh_cur = 3'b000;
        for (int i = 1; i <= 4; i++) begin
            run_to_boundary();
            chk("release_slew", 1, 0, o_act(1, 0), 32'(CTR + SLEW_B * i));
        end

        // Write exactly in the boundary cycle waits one extra frame.
        run_to_pre_boundary();
        step(3'b010, 0, 170, 0);
        chk("bnd_write_hold", 0, 1, o_act(0, 1), 32'd120);
        run_to_boundary();
        chk("bnd_write_apply", 0, 1, o_act(0, 1), 32'd170);

        // Randomised traffic against the model.
        for (int i = 0; i < 40 * P; i++) begin
            logic [2:0] we;
            int c[N_CH];
            for (int k = 0; k < N_CH; k++) begin
                we[k] = ($urandom_range(0, 199) == 0);
                c[k]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2047))
                                                    : int'($urandom_range(60, 240));
                if ($urandom_range(0, 1999) == 0) inh_cur[k] = ~inh_cur[k];
            end
            step(we, c[0], c[1], c[2]);
        end
        inh_cur = '0;

        // Reset asserted mid-pulse: outputs drop within the same cycle.
        run_to_boundary();
        idle(40);
        chk("pre_reset_high", 1, 1, o_pwm(1, 1), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < N_CH; k++)
                chk("async_reset_pwm", d, k, o_pwm(d, k), 32'd0);
        repeat (5) begin
            @(negedge clk);
            chk_reset();
        end
        model_reset();
        rst = 1'b1;
        hi  = 0;
        for (int i = 0; i < P; i++) begin
            idle(1);
            hi += int'(pwm_b[1]);
        end
        chk("restart_pulse_len", 1, 1, 32'(hi), 32'(CTR * DIV));
        idle(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
